window_gen_kxk: RTL and testbench



---
 rtl/window_gen_kxk.sv | 109 ++++++++++
 tb/tb_window_gen_kxk.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/window_gen_kxk.sv
// KxK sliding-window generator: raster pixel stream in, one flattened window out per
// valid convolution position, with KSIZE-1 internal line buffers and valid/ready flow control.
module window_gen_kxk #(
  parameter int DATA_WIDTH = 16,
  parameter int KSIZE      = 3,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32
) (
  input  logic                                clk,
  input  logic                                Rst_window,
  input  logic                                Clr_window,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [DATA_WIDTH-1:0]        in_pixel,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [KSIZE*KSIZE*DATA_WIDTH-1:0]   out_window,
  output logic [$clog2(IMG_HEIGHT)-1:0]       out_row,
  output logic [$clog2(IMG_WIDTH)-1:0]        out_col,
  output logic                                frame_done
);

  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH);

  logic [DATA_WIDTH-1:0] win [KSIZE][KSIZE];
  logic [DATA_WIDTH-1:0] lb  [KSIZE-1][IMG_WIDTH];
  logic [RW-1:0]         row_cnt;
  logic [CW-1:0]         col_cnt;
  logic                  accept;
  logic                  row_last;
  logic                  col_last;
  logic                  win_ok;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !Clr_window;
  assign col_last = (col_cnt == CW'(IMG_WIDTH - 1));
  assign row_last = (row_cnt == RW'(IMG_HEIGHT - 1));
  // Only positions fully inside the current frame's rows and columns are valid
  assign win_ok   = (row_cnt >= RW'(KSIZE - 1)) && (col_cnt >= CW'(KSIZE - 1));

  always_ff @(posedge clk or negedge Rst_window) begin
    if (!Rst_window) begin
      for (int r = 0; r < KSIZE; r++)
        for (int c = 0; c < KSIZE; c++)
          win[r][c] <= '0;
    end else if (Clr_window) begin
      for (int r = 0; r < KSIZE; r++)
        for (int c = 0; c < KSIZE; c++)
          win[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < KSIZE; r++)
        for (int c = 1; c < KSIZE; c++)
          win[r][c] <= win[r][c-1];
      win[KSIZE-1][0] <= in_pixel;
      for (int r = 0; r < KSIZE - 1; r++)
        win[r][0] <= lb[KSIZE-2-r][col_cnt];
    end
  end

  // Line buffers are plain storage; stale contents are masked by win_ok
  always_ff @(posedge clk) begin
    if (accept) begin
      lb[0][col_cnt] <= in_pixel;
      for (int i = 1; i < KSIZE - 1; i++)
        lb[i][col_cnt] <= lb[i-1][col_cnt];
    end
  end

  always_ff @(posedge clk or negedge Rst_window) begin
    if (!Rst_window) begin
      row_cnt    <= '0;
      col_cnt    <= '0;
      out_valid  <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
    end else if (Clr_window) begin
      row_cnt    <= '0;
      col_cnt    <= '0;
      out_valid  <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && row_last && col_last;
      if (accept) begin
        out_valid <= win_ok;
        out_row   <= row_cnt;
        out_col   <= col_cnt;
        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= row_last ? '0 : row_cnt + RW'(1);
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  for (genvar r = 0; r < KSIZE; r++) begin : g_row
    for (genvar c = 0; c < KSIZE; c++) begin : g_col
      assign out_window[(r*KSIZE+c)*DATA_WIDTH +: DATA_WIDTH] = win[r][c];
    end
  end

endmodule

// File: tb/tb_window_gen_kxk.sv
// Directed bench for window_gen_kxk with a 5x4 image, 3x3 window and pixel = row*16+col.
module tb_window_gen_kxk;
  localparam int DW = 16;
  localparam int K  = 3;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int WW = K*K*DW;

  logic                 clk = 1'b0;
  logic                 Rst_window;
  logic                 Clr_window;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_pixel;
  logic                 out_valid;
  logic                 out_ready;
  logic [WW-1:0]        out_window;
  logic [1:0]           out_row;
  logic [2:0]           out_col;
  logic                 frame_done;

  always #5 clk = ~clk;

  window_gen_kxk #(.DATA_WIDTH(DW), .KSIZE(K), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .Rst_window(Rst_window), .Clr_window(Clr_window),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_window(out_window),
    .out_row(out_row), .out_col(out_col), .frame_done(frame_done)
  );

  int n_chk = 0;
  int n_err = 0;
  bit m_valid, m_fd;
  int m_r, m_c, m_wr, m_wc;
  int n_acc, n_win, n_fd;

  task automatic chk(input string tag, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int r, input int c);
    return DW'(r*16 + c);
  endfunction

  // Window whose newest pixel is (r,c): row i is image row r-(K-1)+i, column j is image col c-j
  function automatic logic [WW-1:0] exp_win(input int r, input int c);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        w[(i*K+j)*DW +: DW] = pix(r - (K-1) + i, c - j);
    return w;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_fd = 0;
    m_r = 0; m_c = 0; m_wr = 0; m_wc = 0;
  endtask

  // Entered and left at a falling edge
  task automatic cycle(input logic v, input logic ordy, input logic clr);
    logic acc, exp_rdy;
    in_valid   = v;
    in_pixel   = pix(m_r, m_c);
    out_ready  = ordy;
    Clr_window = clr;
    exp_rdy    = !m_valid || ordy;
    #1;
    chk("in_ready", in_ready, exp_rdy);
    if (out_valid && ordy) n_win++;
    @(posedge clk);
    acc = v && exp_rdy && !clr;
    if (clr) begin
      model_reset();
    end else if (acc) begin
      m_valid = (m_r >= K-1) && (m_c >= K-1);
      m_wr = m_r; m_wc = m_c;
      m_fd = (m_r == H-1) && (m_c == W-1);
      n_acc++;
      if (m_c == W-1) begin
        m_c = 0;
        m_r = (m_r == H-1) ? 0 : m_r + 1;
      end else begin
        m_c++;
      end
    end else begin
      m_fd = 0;
      if (ordy) m_valid = 0;
    end
    @(negedge clk);
    Clr_window = 1'b0;
    chk("out_valid", out_valid, m_valid);
    chk("frame_done", frame_done, m_fd);
    if (frame_done) n_fd++;
    if (m_valid) begin
      chk("out_row", out_row, m_wr);
      chk("out_col", out_col, m_wc);
      chk("out_window", out_window, exp_win(m_wr, m_wc));
    end
  endtask

  // mode 0: continuous, 1: 5-cycle back-pressure after first window, 2: input bubbles
  task automatic run_frame(input int mode, input string name);
    int cyc, bp;
    bit seen;
    logic v, o;
    cyc = 0; bp = 0; seen = 0;
    n_acc = 0; n_win = 0; n_fd = 0;
    while ((n_acc < W*H || m_valid) && cyc < 300) begin
      v = 1'b1; o = 1'b1;
      if (mode == 2) v = ($urandom_range(0, 3) != 0);
      if (mode == 1 && m_valid && !seen) begin seen = 1; bp = 5; end
      if (bp > 0) begin o = 1'b0; bp--; end
      if (n_acc >= W*H) v = 1'b0;
      cycle(v, o, 1'b0);
      cyc++;
    end
    chk({name, " timeout"}, cyc < 300, 1);
    chk({name, " windows"}, n_win, (H-K+1)*(W-K+1));
    chk({name, " frame_done pulses"}, n_fd, 1);
  endtask

  initial begin
    Rst_window = 1'b0; Clr_window = 1'b0; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset out_window", out_window, 0);
    chk("reset out_row", out_row, 0);
    chk("reset out_col", out_col, 0);
    chk("reset frame_done", frame_done, 0);
    Rst_window = 1'b1;
    @(negedge clk);

    run_frame(0, "continuous");
    run_frame(1, "backpressure");
    run_frame(2, "bubbles");

    // Clear lands on the cycle that would accept 0x23
    repeat (13) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    chk("clr out_valid", out_valid, 0);
    run_frame(0, "after clear");

    // Asynchronous reset between edges while a window is held
    repeat (14) cycle(1'b1, 1'b1, 1'b0);
    out_ready = 1'b0; in_valid = 1'b0;
    #2 Rst_window = 1'b0;
    #1;
    chk("async rst out_valid", out_valid, 0);
    chk("async rst in_ready", in_ready, 1);
    chk("async rst out_window", out_window, 0);
    chk("async rst frame_done", frame_done, 0);
    model_reset();
    @(negedge clk);
    Rst_window = 1'b1;
    run_frame(0, "after reset");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
